// File: rtl/nvm_cmd_pkg.sv
// nvm_cmd_pkg: shared types and constants for the nvmain command issuer.
//   - opcode ASCII constants and the case bit that separates query and issue forms
//   - issuer state enum
//   - cmd_t: one command-table entry (arg0..arg4)
package nvm_cmd_pkg;

    localparam logic [7:0] OP_L     = 8'h4C;
    localparam logic [7:0] OP_C     = 8'h43;
    localparam logic [7:0] OP_R     = 8'h52;
    localparam logic [7:0] OP_W     = 8'h57;
    localparam logic [7:0] OP_A     = 8'h41;
    localparam logic [7:0] CASE_BIT = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        WAIT,
        ISSUE,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  arg0;
        logic [31:0] arg1;
        logic [31:0] arg2;
        logic [31:0] arg3;
        logic [7:0]  arg4;
    } cmd_t;

endpackage

// File: rtl/nvm_cmd_issuer_if.sv
// nvm_cmd_issuer_if: command bus between the issuer and the nvmain bridge.
//   command_enable  one-cycle command strobe (issuer -> bridge)
//   arg0..arg4      opcode, address/length/stride, mode (issuer -> bridge)
//   is_issuable     bridge ready indication (bridge -> issuer)
interface nvm_cmd_issuer_if;

    logic        command_enable;
    logic [7:0]  arg0;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic [31:0] arg3;
    logic [7:0]  arg4;
    logic        is_issuable;

    modport master (
        output command_enable, arg0, arg1, arg2, arg3, arg4,
        input  is_issuable
    );

    modport slave (
        input  command_enable, arg0, arg1, arg2, arg3, arg4,
        output is_issuable
    );

endinterface

// File: rtl/nvm_cmd_table.sv
// nvm_cmd_table: DEPTH x cmd_t register file.
//   clk      clock
//   wr_en    write strobe (synchronous write)
//   wr_addr  write index
//   wr_data  entry to write
//   rd_addr  read index
//   rd_data  combinational read of rd_addr
// Contents are deliberately not reset.
module nvm_cmd_table
    import nvm_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  cmd_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output cmd_t          rd_data
);

    cmd_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nvm_cmd_issuer.sv
// nvm_cmd_issuer: walks a host-loaded command table and drives the nvmain
// bridge with a lowercase query, waits for is_issuable, then an uppercase issue.
//   clk, rst_n              clock, synchronous active-low reset
//   tbl_wr_*                host table write port (ignored while busy)
//   start, num_cmds, loop_en run control (latched on an accepted start)
//   stop                    early termination request
//   bus                     command bus (master side)
//   busy, done              run status; done is a one-cycle pulse
//   issued_count            issue pulses since reset (wraps)
//   stall_cycles            WAIT cycles with is_issuable=0, saturating;
//                           present only when NVM_ISSUER_STATS_EN is defined
//
// state | meaning
// IDLE  | waiting for start
// QUERY | query pulse (lowercase opcode) for entry idx
// WAIT  | waiting for is_issuable; re-query after RETRY_GAP cycles
// ISSUE | issue pulse (uppercase opcode) for entry idx
// HOLD  | ISSUE_GAP idle cycles before the next entry
// DONE  | one-cycle done pulse, back to IDLE
module nvm_cmd_issuer
    import nvm_cmd_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int RETRY_GAP = 8,
    parameter int ISSUE_GAP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tbl_wr_en,
    input  logic [AW-1:0] tbl_wr_addr,
    input  logic [7:0]    tbl_wr_arg0,
    input  logic [31:0]   tbl_wr_arg1,
    input  logic [31:0]   tbl_wr_arg2,
    input  logic [31:0]   tbl_wr_arg3,
    input  logic [7:0]    tbl_wr_arg4,
    input  logic          start,
    input  logic [AW:0]   num_cmds,
    input  logic          loop_en,
    input  logic          stop,
    nvm_cmd_issuer_if.master bus,
    output logic          busy,
    output logic          done,
`ifdef NVM_ISSUER_STATS_EN
    output logic [31:0]   stall_cycles,
`endif
    output logic [31:0]   issued_count
);

    localparam int GMAX = (RETRY_GAP > ISSUE_GAP) ? RETRY_GAP : ISSUE_GAP;
    localparam int TW   = $clog2(GMAX) + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   num_q, num_d;
    logic          loop_q, loop_d;
    logic          stop_q, stop_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          start_bad;
    logic          last_entry;
    cmd_t          rd_cmd;
    cmd_t          wr_cmd;

    logic          cmd_en_q;
    cmd_t          out_q;
    logic          busy_q, done_q;
    logic [31:0]   issued_q;

    assign wr_cmd = '{arg0: tbl_wr_arg0, arg1: tbl_wr_arg1, arg2: tbl_wr_arg2,
                      arg3: tbl_wr_arg3, arg4: tbl_wr_arg4};

    // Read at the next index so the registered args line up with the pulse.
    nvm_cmd_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en & ~busy_q),
        .wr_addr (tbl_wr_addr),
        .wr_data (wr_cmd),
        .rd_addr (idx_d),
        .rd_data (rd_cmd)
    );

    assign last_entry = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            loop_q  <= 1'b0;
            stop_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            loop_q  <= loop_d;
            stop_q  <= stop_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        tmr_d     = tmr_q;
        start_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_cmds != '0 && num_cmds <= (AW+1)'(DEPTH)) begin
                        state_d = QUERY;
                        idx_d   = '0;
                        num_d   = num_cmds;
                        loop_d  = loop_en;
                        stop_d  = 1'b0;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            QUERY: begin
                // WAIT lasts RETRY_GAP-1 cycles so queries are RETRY_GAP apart.
                tmr_d   = TW'(RETRY_GAP - 2);
                state_d = stop ? DONE : WAIT;
            end
            WAIT: begin
                if (stop) begin
                    state_d = DONE;
                end else if (bus.is_issuable) begin
                    state_d = ISSUE;
                end else if (tmr_q == '0) begin
                    state_d = QUERY;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ISSUE: begin
                tmr_d   = TW'(ISSUE_GAP - 1);
                stop_d  = stop;
                state_d = HOLD;
            end
            HOLD: begin
                stop_d = stop_q | stop;
                if (tmr_q == '0) begin
                    if (stop_q || stop) begin
                        state_d = DONE;
                    end else if (last_entry) begin
                        if (loop_q) begin
                            idx_d   = '0;
                            state_d = QUERY;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = QUERY;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they coincide with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_en_q <= 1'b0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            cmd_en_q <= (state_d == QUERY) || (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE) || start_bad;
            if (state_d == QUERY) begin
                out_q      <= rd_cmd;
                out_q.arg0 <= rd_cmd.arg0 | CASE_BIT;
            end else if (state_d == ISSUE) begin
                out_q      <= rd_cmd;
                out_q.arg0 <= rd_cmd.arg0 & ~CASE_BIT;
                issued_q   <= issued_q + 32'd1;
            end
        end
    end

`ifdef NVM_ISSUER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && state_d == QUERY) begin
            stall_q <= '0;
        end else if (state_q == WAIT && !bus.is_issuable && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.command_enable = cmd_en_q;
    assign bus.arg0           = out_q.arg0;
    assign bus.arg1           = out_q.arg1;
    assign bus.arg2           = out_q.arg2;
    assign bus.arg3           = out_q.arg3;
    assign bus.arg4           = out_q.arg4;
    assign busy               = busy_q;
    assign done               = done_q;
    assign issued_count       = issued_q;

endmodule

// File: tb/tb_nvm_cmd_issuer.sv
// tb_nvm_cmd_issuer: randomized and directed checks of nvm_cmd_issuer against
// a transaction-level timeline model (slot 0 = first query cycle).
module tb_nvm_cmd_issuer;
    import nvm_cmd_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int RG    = 8;
    localparam int IG    = 2;
    localparam int MAXS  = 600;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tbl_wr_en = 1'b0;
    logic [AW-1:0] tbl_wr_addr = '0;
    logic [7:0]    tbl_wr_arg0 = '0;
    logic [31:0]   tbl_wr_arg1 = '0;
    logic [31:0]   tbl_wr_arg2 = '0;
    logic [31:0]   tbl_wr_arg3 = '0;
    logic [7:0]    tbl_wr_arg4 = '0;
    logic          start = 1'b0;
    logic [AW:0]   num_cmds = '0;
    logic          loop_en = 1'b0;
    logic          stop = 1'b0;
    logic          busy, done;
    logic [31:0]   issued_count;
`ifdef NVM_ISSUER_STATS_EN
    logic [31:0]   stall_cycles;
`endif

    nvm_cmd_issuer_if bus ();

    nvm_cmd_issuer #(.DEPTH(DEPTH), .AW(AW), .RETRY_GAP(RG), .ISSUE_GAP(IG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_arg0  (tbl_wr_arg0),
        .tbl_wr_arg1  (tbl_wr_arg1),
        .tbl_wr_arg2  (tbl_wr_arg2),
        .tbl_wr_arg3  (tbl_wr_arg3),
        .tbl_wr_arg4  (tbl_wr_arg4),
        .start        (start),
        .num_cmds     (num_cmds),
        .loop_en      (loop_en),
        .stop         (stop),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
`ifdef NVM_ISSUER_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    cmd_t           tbl_m [DEPTH];
    bit             iss [MAXS];
    logic [127:0]   exp_q [$];
    logic [127:0]   obs_q [$];
    int             total_issued = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {slot[15:0], arg0, arg1, arg2, arg3, arg4}
    function automatic logic [127:0] pack(input int slot, input cmd_t c, input bit q);
        logic [7:0] a0;
        a0 = q ? (c.arg0 | 8'h20) : (c.arg0 & 8'hDF);
        return {slot[15:0], a0, c.arg1, c.arg2, c.arg3, c.arg4};
    endfunction

    function automatic logic [127:0] pack_bus(input int slot);
        return {slot[15:0], bus.arg0, bus.arg1, bus.arg2, bus.arg3, bus.arg4};
    endfunction

    task automatic load(input int addr, input cmd_t c);
        @(negedge clk);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = addr[AW-1:0];
        {tbl_wr_arg0, tbl_wr_arg1, tbl_wr_arg2, tbl_wr_arg3, tbl_wr_arg4} = c;
        tbl_m[addr] = c;
        @(negedge clk);
        tbl_wr_en = 1'b0;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        logic [7:0] ops [5];
        ops[0] = OP_L; ops[1] = OP_C; ops[2] = OP_R; ops[3] = OP_W; ops[4] = OP_A;
        c.arg0 = ops[$urandom_range(0, 4)] | ($urandom_range(0, 1) ? 8'h20 : 8'h00);
        c.arg1 = $urandom;
        c.arg2 = $urandom;
        c.arg3 = $urandom;
        c.arg4 = $urandom_range(0, 1) ? 8'h58 : 8'h59;
        return c;
    endfunction

    // Timeline model: each query is followed by up to RG-1 wait slots; the
    // first ready wait slot s gives an issue at s+1, then IG hold slots.
    task automatic run_model(input int n, input bit lp, input int sp,
                             output int done_slot, output int issues,
                             output int stalls, output int issue5);
        int t, idx, s;
        bit fin, found;
        t = 0; idx = 0; fin = 0;
        exp_q.delete();
        done_slot = -1; issues = 0; stalls = 0; issue5 = -1;
        while (!fin && t < MAXS - 20) begin
            exp_q.push_back(pack(t, tbl_m[idx], 1'b1));
            if (sp == t) begin
                done_slot = t + 1; fin = 1;
            end else begin
                found = 0; s = t;
                for (int k = 1; k < RG; k++) begin
                    s = t + k;
                    if (!iss[s]) stalls++;
                    if (sp == s) begin done_slot = s + 1; fin = 1; break; end
                    if (iss[s]) begin found = 1; break; end
                end
                if (!fin) begin
                    if (found) begin
                        exp_q.push_back(pack(s + 1, tbl_m[idx], 1'b0));
                        issues++;
                        if (issues == 5) issue5 = s + 1;
                        if (sp >= s + 1 && sp <= s + 1 + IG) begin
                            done_slot = s + 2 + IG; fin = 1;
                        end else if (idx == n - 1 && !lp) begin
                            done_slot = s + 2 + IG; fin = 1;
                        end else begin
                            idx = (idx == n - 1) ? 0 : idx + 1;
                            t = s + 2 + IG;
                        end
                    end else begin
                        t = t + RG;
                    end
                end
            end
        end
    endtask

    task automatic run_dut(input string nm, input int n, input bit lp, input int sp,
                           input int done_slot, input int issues, input int stalls,
                           input bit wr_during);
        int obs_done;
        obs_done = -1;
        obs_q.delete();
        @(negedge clk);
        start = 1'b1; num_cmds = n[AW:0]; loop_en = lp; stop = 1'b0;
        bus.is_issuable = 1'b0;
        for (int r = 0; r < MAXS; r++) begin
            @(negedge clk);
            if (bus.command_enable) obs_q.push_back(pack_bus(r));
            if (done && obs_done < 0) obs_done = r;
            if (r == 0) check({nm, ".busy_run"}, busy, 1'b1);
            start = 1'b0;
            bus.is_issuable = iss[r];
            stop = (r == sp);
            tbl_wr_en = (wr_during && r == 2 && done_slot > 4);
            if (tbl_wr_en) begin
                tbl_wr_addr = '0;
                {tbl_wr_arg0, tbl_wr_arg1, tbl_wr_arg2, tbl_wr_arg3, tbl_wr_arg4} = rand_cmd();
            end
            if (done_slot >= 0 && r == done_slot + 1) break;
        end
        stop = 1'b0; bus.is_issuable = 1'b0; tbl_wr_en = 1'b0;
        total_issued += issues;
        check({nm, ".n_pulses"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({nm, ".pulse"}, obs_q[i], exp_q[i]);
        check({nm, ".done_slot"}, obs_done, done_slot);
        check({nm, ".busy_after"}, busy, 1'b0);
        check({nm, ".issued_count"}, issued_count, total_issued);
`ifdef NVM_ISSUER_STATS_EN
        check({nm, ".stall_cycles"}, stall_cycles, stalls);
`else
        if (stalls < 0) $display("negative stall count");
`endif
    endtask

    initial begin
        int d, ni, st, i5;
        cmd_t c;

        bus.is_issuable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.cmd_en", bus.command_enable, 1'b0);
        check("rst.args", {bus.arg0, bus.arg1, bus.arg2, bus.arg3, bus.arg4}, '0);
        check("rst.busy_done", {busy, done}, 2'b00);
        check("rst.issued", issued_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, rand_cmd());

        // Two-entry pass with the bridge always ready.
        load(0, '{arg0: OP_L, arg1: 32'h0, arg2: 32'h10000, arg3: 32'h1, arg4: 8'h58});
        load(1, '{arg0: OP_C, arg1: 32'h10000, arg2: 32'h10000, arg3: 32'h10000, arg4: 8'h58});
        for (int i = 0; i < MAXS; i++) iss[i] = 1'b1;
        run_model(2, 1'b0, -1, d, ni, st, i5);
        run_dut("basic", 2, 1'b0, -1, d, ni, st, 1'b0);
        check("basic.a0_0", obs_q[0][111:104], 8'h6C);
        check("basic.a0_1", obs_q[1][111:104], 8'h4C);
        check("basic.a0_2", obs_q[2][111:104], 8'h63);
        check("basic.a0_3", obs_q[3][111:104], 8'h43);
        check("basic.count", issued_count, 2);

        // Bridge not ready for 20 cycles: re-queries at 0, 8, 16.
        for (int i = 0; i < MAXS; i++) iss[i] = (i >= 20);
        run_model(1, 1'b0, -1, d, ni, st, i5);
        run_dut("retry", 1, 1'b0, -1, d, ni, st, 1'b0);
        check("retry.q0", obs_q[0][127:112], 0);
        check("retry.q1", obs_q[1][127:112], 8);
        check("retry.q2", obs_q[2][127:112], 16);
        check("retry.issue", obs_q[3][111:104], 8'h4C);

        // 12 stalled WAIT cycles before the issue.
        for (int i = 0; i < MAXS; i++) iss[i] = (i >= 14);
        run_model(1, 1'b0, -1, d, ni, st, i5);
        check("stall12.model", st, 12);
        run_dut("stall12", 1, 1'b0, -1, d, ni, st, 1'b0);

        // Loop with stop on the fifth issue pulse.
        for (int i = 0; i < MAXS; i++) iss[i] = ($urandom_range(0, 2) != 0);
        run_model(2, 1'b1, -1, d, ni, st, i5);
        run_model(2, 1'b1, i5, d, ni, st, i5);
        check("loop.issues", ni, 5);
        run_dut("loop", 2, 1'b1, i5, d, ni, st, 1'b0);

        // Out-of-range run lengths.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; num_cmds = (k == 0) ? 5'd0 : 5'd17; loop_en = 1'b0;
            @(negedge clk);
            start = 1'b0;
            check("bad.done", done, 1'b1);
            check("bad.busy_cmd", {busy, bus.command_enable}, 2'b00);
            @(negedge clk);
            check("bad.after", {done, busy, bus.command_enable}, 3'b000);
        end

        // Reset while in WAIT.
        for (int i = 0; i < MAXS; i++) iss[i] = 1'b0;
        @(negedge clk);
        start = 1'b1; num_cmds = 5'd3; loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("wrst.busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("wrst.outs", {bus.command_enable, busy, done, issued_count,
                            bus.arg0, bus.arg1, bus.arg2, bus.arg3, bus.arg4}, '0);
        rst_n = 1'b1;
        total_issued = 0;

        // Randomized runs.
        for (int j = 0; j < 12; j++) begin
            int n, sp, p;
            bit lp;
            n  = $urandom_range(1, DEPTH);
            lp = ($urandom_range(0, 3) == 0);
            p  = $urandom_range(1, 4);
            for (int i = 0; i < MAXS; i++) iss[i] = ($urandom_range(0, p) == 0);
            if (lp) sp = $urandom_range(0, 150);
            else sp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 80) : -1;
            run_model(n, lp, sp, d, ni, st, i5);
            run_dut("rand", n, lp, sp, d, ni, st, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
